alocador_aste: RTL and testbench
================================

Name: alocador_aste

Overview:
Slot allocator that sits directly upstream of the 16 x 2-bit asteroid load memory and is the only master of its write and clear ports.
- On a spawn request it scans the memory for the lowest free slot (code 00), marks it active (01) and returns the slot index, or reports full.
- On a destroy request it frees a given slot.
- It keeps a live count of occupied slots and can clear the whole memory.

Parameters:
N_SLOTS, 16, number of memory entries; must equal 2**ADDR_W.
ADDR_W, 4, memory address width.
DATA_W, 2, memory data width.
COD_LIVRE, 2'b00, free-slot code.
COD_ATIVO, 2'b01, code written on spawn.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
spawn  in  1  request: allocate a slot (level sampled in IDLE).
destroi  in  1  request: free slot destroi_addr.
destroi_addr  in  ADDR_W  slot to free.
limpa_tudo  in  1  request: clear entire memory.
mem_q  in  DATA_W  memory read data; registered-address read, valid one cycle after mem_addr is driven.
mem_addr  out  ADDR_W  memory address.
mem_data  out  DATA_W  memory write data.
mem_we  out  1  memory write enable.
mem_clear  out  1  memory clear.
ocupado  out  1  high whenever state is not IDLE.
spawn_ok  out  1  one-cycle pulse: allocation done.
spawn_cheio  out  1  one-cycle pulse: no free slot.
slot_out  out  ADDR_W  last allocated slot; held until next allocation.
n_ativos  out  ADDR_W+1  occupied-slot count, 0..N_SLOTS.

Behaviour:
- States: LIMPA, IDLE, BUSCA, GRAVA, CHEIO, REMOVE_LE, REMOVE_GR.
- Outputs are registered or Moore-decoded from the state, except mem_we and the decrement in REMOVE_GR.
- Reset (asynchronous, reset_n=0):
  - State = LIMPA; idx = 0; slot_out = 0; n_ativos = 0.
  - mem_clear = 1, ocupado = 1; all other outputs 0.
  - The first cycle after release completes the clear, then the block goes to IDLE. Counter and memory are therefore always consistent after reset.
- LIMPA (1 cycle):
  - mem_clear = 1, n_ativos <= 0, then IDLE.
  - Entered from ANY state when limpa_tudo = 1. This aborts any scan or remove, with no spawn_ok, spawn_cheio or write in that cycle.
- IDLE:
  - Request priority: limpa_tudo > destroi > spawn.
  - destroi goes to REMOVE_LE and latches destroi_addr.
  - spawn with n_ativos == N_SLOTS goes directly to CHEIO.
  - spawn otherwise goes to BUSCA with idx = 0.
  - While ocupado = 1, spawn and destroi are ignored, not queued.
- BUSCA (pipelined, one address per cycle):
  - mem_addr = idx (ADDR_W bits, wraps); idx increments each cycle.
  - From the second BUSCA cycle on, mem_q holds ram[idx-1].
  - If mem_q == COD_LIVRE: slot = idx-1, go to GRAVA.
  - If slot N_SLOTS-1 is examined and occupied: go to CHEIO.
- GRAVA (1 cycle):
  - mem_addr = slot, mem_data = COD_ATIVO, mem_we = 1.
  - spawn_ok = 1; slot_out <= slot; n_ativos <= n_ativos + 1. Then IDLE.
- CHEIO (1 cycle): spawn_cheio = 1, no write, then IDLE.
- Spawn timing (spawn sampled in IDLE at cycle T):
  - Lowest free slot k: GRAVA at T+3+k.
  - All slots occupied but counter < N_SLOTS: CHEIO at T+18.
  - Counter == N_SLOTS: CHEIO at T+1.
- REMOVE_LE (1 cycle): mem_addr = latched address, then REMOVE_GR.
- REMOVE_GR (1 cycle):
  - mem_addr = latched address; mem_data = COD_LIVRE.
  - mem_we = (mem_q != COD_LIVRE).
  - If mem_q != COD_LIVRE, n_ativos <= n_ativos - 1.
  - Freeing an already-free slot is a no-op: no write, no decrement.
  - Then IDLE.
- Outside GRAVA and REMOVE_GR: mem_we = 0 and mem_data = 0.
- Outside LIMPA: mem_clear = 0.
- In IDLE: mem_addr = 0.
- n_ativos never wraps: no increment at N_SLOTS, no decrement at 0 (guarded).

Test Plan:
- Reset release → mem_clear = 1 for exactly 1 cycle, then ocupado = 0, n_ativos = 0; all memory entries read 00.
- Empty memory, spawn at T → GRAVA at T+3 writes 01 to addr 0; spawn_ok pulse with slot_out = 0; n_ativos = 1.
- Slots 0..4 occupied, 5 free, spawn → write at T+8 to addr 5; slot_out = 5; n_ativos += 1.
- 16 spawns back-to-back (each issued in IDLE) → slot_out = 0..15 in order, n_ativos = 16; 17th spawn → spawn_cheio at T+1, no mem_we.
- destroi_addr = 7 on an occupied slot → mem_we = 1 with data 00 at T+2, n_ativos -1; repeat on slot 7 → no mem_we, count unchanged; next spawn returns slot 7.
- limpa_tudo asserted mid-scan (during BUSCA of a spawn) → next cycle LIMPA with mem_clear = 1, no spawn_ok or write, n_ativos = 0.

Source files
------------

// File: rtl/alocador_aste.sv
// Slot allocator in front of the 16 x 2-bit asteroid memory: finds the lowest
// free slot on spawn, frees a slot on destroy, tracks the occupied count.
module alocador_aste #(
  parameter int                N_SLOTS   = 16,
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 2,
  parameter logic [DATA_W-1:0] COD_LIVRE = 2'b00,
  parameter logic [DATA_W-1:0] COD_ATIVO = 2'b01
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spawn,
  input  logic              destroi,
  input  logic [ADDR_W-1:0] destroi_addr,
  input  logic              limpa_tudo,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_clear,
  output logic              ocupado,
  output logic              spawn_ok,
  output logic              spawn_cheio,
  output logic [ADDR_W-1:0] slot_out,
  output logic [ADDR_W:0]   n_ativos
);

  typedef enum logic [2:0] {
    LIMPA, IDLE, BUSCA, GRAVA, CHEIO, REMOVE_LE, REMOVE_GR
  } state_t;

  localparam logic [ADDR_W:0] LP_N = (ADDR_W+1)'(N_SLOTS);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W:0]     r_idx;
  logic [ADDR_W-1:0]   r_slot;
  logic [ADDR_W-1:0]   r_addr_rm;
  logic [ADDR_W-1:0]   r_slot_out;
  logic [ADDR_W:0]     r_n_ativos;
  logic                w_q_livre;

  assign w_q_livre = (mem_q == COD_LIVRE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= LIMPA;
    else          r_state <= w_next;
  end

  // r_idx is one bit wider than the address so that idx==0 marks the first
  // scan cycle (no read data yet) and idx==N_SLOTS marks the last slot seen.
  always_comb begin
    w_next = r_state;
    case (r_state)
      LIMPA:     w_next = IDLE;
      IDLE: begin
        if (destroi)    w_next = REMOVE_LE;
        else if (spawn) w_next = (r_n_ativos == LP_N) ? CHEIO : BUSCA;
      end
      BUSCA: begin
        if (r_idx != '0) begin
          if (w_q_livre)          w_next = GRAVA;
          else if (r_idx == LP_N) w_next = CHEIO;
        end
      end
      GRAVA:     w_next = IDLE;
      CHEIO:     w_next = IDLE;
      REMOVE_LE: w_next = REMOVE_GR;
      REMOVE_GR: w_next = IDLE;
      default:   w_next = LIMPA;
    endcase
    if (limpa_tudo) w_next = LIMPA;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_slot     <= '0;
      r_addr_rm  <= '0;
      r_slot_out <= '0;
      r_n_ativos <= '0;
    end else begin
      case (r_state)
        LIMPA: r_n_ativos <= '0;
        IDLE: begin
          r_idx <= '0;
          if (destroi) r_addr_rm <= destroi_addr;
        end
        BUSCA: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx != '0 && w_q_livre) r_slot <= r_idx[ADDR_W-1:0] - 1'b1;
        end
        GRAVA: begin
          r_slot_out <= r_slot;
          if (r_n_ativos != LP_N) r_n_ativos <= r_n_ativos + 1'b1;
        end
        REMOVE_GR: begin
          if (!w_q_livre && r_n_ativos != '0) r_n_ativos <= r_n_ativos - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_data    = '0;
    mem_we      = 1'b0;
    mem_clear   = 1'b0;
    spawn_ok    = 1'b0;
    spawn_cheio = 1'b0;
    case (r_state)
      LIMPA: mem_clear = 1'b1;
      BUSCA: mem_addr = r_idx[ADDR_W-1:0];
      GRAVA: begin
        mem_addr = r_slot;
        mem_data = COD_ATIVO;
        mem_we   = 1'b1;
        spawn_ok = 1'b1;
      end
      CHEIO:     spawn_cheio = 1'b1;
      REMOVE_LE: mem_addr = r_addr_rm;
      REMOVE_GR: begin
        mem_addr = r_addr_rm;
        mem_data = COD_LIVRE;
        mem_we   = !w_q_livre;
      end
      default: ;
    endcase
  end

  assign ocupado  = (r_state != IDLE);
  assign slot_out = r_slot_out;
  assign n_ativos = r_n_ativos;

endmodule

// File: tb/tb_alocador_aste.sv
// Directed bench for alocador_aste with a behavioural 16 x 2-bit memory
// (registered read address, synchronous clear and write).
module tb_alocador_aste;

  logic       clk;
  logic       reset_n;
  logic       spawn;
  logic       destroi;
  logic [3:0] destroiAddr;
  logic       limpaTudo;
  logic [1:0] memQ;
  logic [3:0] memAddr;
  logic [1:0] memData;
  logic       memWe;
  logic       memClear;
  logic       ocupado;
  logic       spawnOk;
  logic       spawnCheio;
  logic [3:0] slotOut;
  logic [4:0] nAtivos;

  logic [1:0] ram [16] = '{default: 2'b11};
  logic [3:0] rdAddr = 4'd0;
  logic       pokeEn;
  logic [3:0] pokeAddr;

  int total = 0;
  int bad   = 0;

  alocador_aste dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spawn        (spawn),
    .destroi      (destroi),
    .destroi_addr (destroiAddr),
    .limpa_tudo   (limpaTudo),
    .mem_q        (memQ),
    .mem_addr     (memAddr),
    .mem_data     (memData),
    .mem_we       (memWe),
    .mem_clear    (memClear),
    .ocupado      (ocupado),
    .spawn_ok     (spawnOk),
    .spawn_cheio  (spawnCheio),
    .slot_out     (slotOut),
    .n_ativos     (nAtivos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; the poke port lets the bench mark a slot occupied behind the
  // allocator's back to build a full memory with a stale counter.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 16; i++) ram[i] <= 2'b00;
    end else if (memWe) begin
      ram[memAddr] <= memData;
    end else if (pokeEn) begin
      ram[pokeAddr] <= 2'b01;
    end
    rdAddr <= memAddr;
  end
  assign memQ = ram[rdAddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic sp, input logic de, input logic [3:0] ad, input logic lt);
    spawn       = sp;
    destroi     = de;
    destroiAddr = ad;
    limpaTudo   = lt;
  endtask

  task automatic checkMemClear();
    for (int i = 0; i < 16; i++) checkOutput($sformatf("ram%0d_clear", i), ram[i], 2'b00);
  endtask

  // Spawn issued in IDLE at T; lowest free slot k must be written at T+3+k.
  task automatic spawnAndCheck(input int k, input logic [4:0] nExp);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (1 + k) tick();
    checkOutput($sformatf("spawn%0d_early_ok", k), spawnOk, 1'b0);
    tick();
    checkOutput($sformatf("spawn%0d_ok", k), spawnOk, 1'b1);
    checkOutput($sformatf("spawn%0d_we", k), memWe, 1'b1);
    checkOutput($sformatf("spawn%0d_addr", k), memAddr, k[3:0]);
    checkOutput($sformatf("spawn%0d_data", k), memData, 2'b01);
    tick();
    checkOutput($sformatf("spawn%0d_slot_out", k), slotOut, k[3:0]);
    checkOutput($sformatf("spawn%0d_n", k), nAtivos, nExp);
    checkOutput($sformatf("spawn%0d_idle", k), ocupado, 1'b0);
  endtask

  initial begin
    pokeEn   = 1'b0;
    pokeAddr = 4'd0;
    reset_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_clear", memClear, 1'b1);
    checkOutput("rst_ocupado", ocupado, 1'b1);
    checkOutput("rst_n", nAtivos, 5'd0);
    checkOutput("rst_slot_out", slotOut, 4'd0);
    checkOutput("rst_we", memWe, 1'b0);
    checkOutput("rst_ok", spawnOk, 1'b0);

    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_clear", memClear, 1'b1);
    tick();
    checkOutput("idle_clear", memClear, 1'b0);
    checkOutput("idle_ocupado", ocupado, 1'b0);
    checkOutput("idle_n", nAtivos, 5'd0);
    checkOutput("idle_addr", memAddr, 4'd0);
    checkMemClear();

    $display("[TB] filling all 16 slots");
    for (int k = 0; k < 16; k++) spawnAndCheck(k, 5'(k + 1));

    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("full_cheio", spawnCheio, 1'b1);
    checkOutput("full_we", memWe, 1'b0);
    checkOutput("full_ok", spawnOk, 1'b0);
    tick();
    checkOutput("full_cheio_pulse", spawnCheio, 1'b0);
    checkOutput("full_n", nAtivos, 5'd16);

    $display("[TB] destroy slot 7");
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("rm_le_addr", memAddr, 4'd7);
    checkOutput("rm_le_we", memWe, 1'b0);
    tick();
    checkOutput("rm_gr_we", memWe, 1'b1);
    checkOutput("rm_gr_addr", memAddr, 4'd7);
    checkOutput("rm_gr_data", memData, 2'b00);
    tick();
    checkOutput("rm_n", nAtivos, 5'd15);
    checkOutput("rm_ram7", ram[7], 2'b00);

    applyStimulus(1'b0, 1'b1, 4'd7, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    checkOutput("rm_again_we", memWe, 1'b0);
    tick();
    checkOutput("rm_again_n", nAtivos, 5'd15);

    spawnAndCheck(7, 5'd16);

    $display("[TB] stale counter: slot 3 freed then refilled behind the allocator");
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("stale_n", nAtivos, 5'd15);
    pokeEn   = 1'b1;
    pokeAddr = 4'd3;
    tick();
    pokeEn = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (16) tick();
    checkOutput("scan_cheio_early", spawnCheio, 1'b0);
    tick();
    checkOutput("scan_cheio", spawnCheio, 1'b1);
    checkOutput("scan_cheio_we", memWe, 1'b0);
    tick();
    checkOutput("scan_cheio_n", nAtivos, 5'd15);

    $display("[TB] destroi has priority over spawn");
    applyStimulus(1'b1, 1'b1, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("prio_addr", memAddr, 4'd3);
    checkOutput("prio_ok", spawnOk, 1'b0);
    tick();
    checkOutput("prio_we", memWe, 1'b1);
    tick();
    checkOutput("prio_n", nAtivos, 5'd14);

    $display("[TB] limpa_tudo during scan");
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("abort_clear", memClear, 1'b1);
    checkOutput("abort_ok", spawnOk, 1'b0);
    checkOutput("abort_we", memWe, 1'b0);
    checkOutput("abort_ocupado", ocupado, 1'b1);
    tick();
    checkOutput("abort_n", nAtivos, 5'd0);
    checkOutput("abort_idle", ocupado, 1'b0);
    checkMemClear();
    repeat (4) begin
      tick();
      checkOutput("abort_no_late_ok", spawnOk, 1'b0);
    end

    spawnAndCheck(0, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
